// File: rtl/coffee_pkg.sv
// rtl/coffee_pkg.sv - shared types and constants for the coffee sensor monitor
// Contents:
//   state_t          monitor state encoding
//   S_WATER..S_CUP   conventional sensor line indices (0 = highest priority)
//   idx_width()      fault index width for a given sensor count (min 1)
package coffee_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ANALYZE  = 3'd1,
        ST_WAIT_FIX = 3'd2,
        ST_OK       = 3'd3,
        ST_FAIL     = 3'd4
    } state_t;

    localparam int S_WATER   = 0;
    localparam int S_CAPSULE = 1;
    localparam int S_CUP     = 2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coffee_sensor_monitor_prio_enc.sv
// rtl/coffee_sensor_monitor_prio_enc.sv - lowest-set-bit priority encoder
// Ports:
//   vec  in   N  request lines, bit 0 = highest priority
//   idx  out  W  index of the lowest set bit (0 when none set)
//   any  out  1  at least one bit set
module prio_enc #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan from the top down so the lowest set bit is the last to write idx.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) idx = W'(i);
        end
    end

    assign any = |vec;

endmodule

// File: rtl/coffee_sensor_monitor.sv
// rtl/coffee_sensor_monitor.sv - pre-brew sensor check with timeout escalation
// Ports:
//   CLK        in   1       rising-edge clock
//   RST_N      in   1       asynchronous active-low reset
//   START      in   1       request a check (IDLE only)
//   CLR        in   1       leave FAIL; zero ERR_CNT in any state
//   SENS       in   N_SENS  fault lines, index 0 = highest priority
//   READY      out  1       all sensors clear, check passed
//   BUSY       out  1       check in progress
//   FAULT      out  1       a fault is being reported
//   FAULT_IDX  out  IDX_W   reported sensor index, 0 when FAULT=0
//   SENS_FAIL  out  1       latched sensor failure
//   ERR_CNT    out  CNT_W   saturating count of fault-window entries
module coffee_sensor_monitor
    import coffee_pkg::*;
#(
    parameter int N_SENS      = 3,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 8,
    parameter int IDX_W       = idx_width(N_SENS)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic              CLR,
    input  logic [N_SENS-1:0] SENS,
    output logic              READY,
    output logic              BUSY,
    output logic              FAULT,
    output logic [IDX_W-1:0]  FAULT_IDX,
    output logic              SENS_FAIL,
    output logic [CNT_W-1:0]  ERR_CNT
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   enc_idx;
    logic               enc_any;
    logic               fault_entry;

    prio_enc #(
        .N (N_SENS),
        .W (IDX_W)
    ) u_prio_enc (
        .vec (SENS),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_W'(S_WATER);
            tmr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        tmr_d       = tmr_q;
        fault_entry = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) state_d = ST_ANALYZE;
            end
            // OK behaves like a continuous re-analysis: any new fault opens a window.
            ST_ANALYZE, ST_OK: begin
                if (enc_any) begin
                    state_d     = ST_WAIT_FIX;
                    idx_d       = enc_idx;
                    tmr_d       = TMR_LOAD;
                    fault_entry = 1'b1;
                end else begin
                    state_d = ST_OK;
                end
            end
            // Only the reported sensor is watched; a higher-priority line that
            // appears meanwhile is picked up once the current one clears.
            ST_WAIT_FIX: begin
                if (SENS[idx_q]) begin
                    if (tmr_q == '0) state_d = ST_FAIL;
                    else             tmr_d   = tmr_q - 1'b1;
                end else if (enc_any) begin
                    idx_d       = enc_idx;
                    tmr_d       = TMR_LOAD;
                    fault_entry = 1'b1;
                end else begin
                    state_d = ST_OK;
                end
            end
            ST_FAIL: begin
                if (CLR) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Clear takes precedence over a same-cycle increment.
        if (CLR)                                cnt_d = '0;
        else if (fault_entry && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
        else                                    cnt_d = cnt_q;
    end

    assign READY     = (state_q == ST_OK);
    assign BUSY      = (state_q == ST_ANALYZE) || (state_q == ST_WAIT_FIX);
    assign FAULT     = (state_q == ST_WAIT_FIX) || (state_q == ST_FAIL);
    assign FAULT_IDX = FAULT ? idx_q : '0;
    assign SENS_FAIL = (state_q == ST_FAIL);
    assign ERR_CNT   = cnt_q;

endmodule
